// File: rtl/cla_multiword_seq.sv
// Multi-word add/subtract sequencer built on a single 8-bit carry-lookahead
// slice adder. One slice is processed per clock, LSB first, with the carry
// held in a register between slices. Valid/ready handshakes on both sides.

// 8-bit carry-lookahead adder: generate/propagate per bit, carries expanded
// from the generate/propagate terms, sum formed from propagate and carries.
module CLA_8bit #(
  parameter int N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Sum,
  output logic         Car
);
  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  // Carry chain from generate/propagate terms, then per-bit sum
  always_comb begin
    g    = A & B;
    p    = A ^ B;
    c    = '0;
    c[0] = Cin;
    for (int i = 0; i < N; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    Sum = p ^ c[N-1:0];
    Car = c[N];
  end
endmodule

module cla_multiword_seq #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORDS*8-1:0]   a,
  input  logic [WORDS*8-1:0]   b,
  input  logic                 cin,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORDS*8-1:0]   sum,
  output logic                 cout,
  output logic                 ovf,
  output logic                 busy
);
  localparam int W  = WORDS * 8;
  localparam int KW = $clog2(WORDS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;      // already inverted for subtract
  logic            carry_q, carry_d;
  logic            sub_q, sub_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [7:0]      a_slice;
  logic [7:0]      b_slice;
  logic [7:0]      cla_sum;
  logic            cla_car;

  // Select the current slice of the latched operands for the shared adder
  always_comb begin
    a_slice = a_q[{k_q, 3'b000} +: 8];
    b_slice = b_q[{k_q, 3'b000} +: 8];
  end

  CLA_8bit #(.N(8)) u_cla (
    .A   (a_slice),
    .B   (b_slice),
    .Cin (carry_q),
    .Sum (cla_sum),
    .Car (cla_car)
  );

  // Next-state and datapath updates for the IDLE/RUN/DONE sequencer
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          sub_d   = sub;
          k_d     = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sum_d[{k_q, 3'b000} +: 8] = cla_sum;
        carry_d = cla_car;
        k_d     = k_q + KW'(1);
        if (k_q == KW'(WORDS - 1)) begin
          cout_d  = cla_car;
          // Same operand signs but result sign differs -> signed overflow
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (cla_sum[7] != a_q[W-1]);
          k_d     = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake and status outputs decode straight from the state register
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    sum       = sum_q;
    cout      = cout_q;
    ovf       = ovf_q;
  end
endmodule

// File: tb/tb_cla_multiword_seq.sv
// Scoreboard bench for cla_multiword_seq (WORDS=4, 32-bit operands).
module tb_cla_multiword_seq;
  localparam int WORDS = 4;
  localparam int W     = WORDS * 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin, sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout, ovf, busy;

  int n_cmp = 0;
  int n_err = 0;

  // expected {ovf, cout, sum}
  logic [W+1:0] exp_q[$];

  // 0 = hold low, 1 = hold high, 2 = random
  int rdy_mode = 1;

  cla_multiword_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
    end
  endtask

  // Independent reference: signed range test for overflow, unsigned compare for borrow
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
    logic [W:0]   u;
    logic [W-1:0] r;
    logic         co, ov;
    longint       sx, sy, res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (s) begin
      r   = x - y;
      co  = (x >= y);
      res = sx - sy;
    end else begin
      u   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      r   = u[W-1:0];
      co  = u[W];
      res = sx + sy + longint'(c);
    end
    ov = (res > 64'sd2147483647) || (res < -64'sd2147483648);
    return {ov, co, r};
  endfunction

  // out_ready driver, updated 2 time units after each rising edge
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
      else               out_ready = (rdy_mode == 1);
    end
  end

  // Monitor: pop and compare on each output handshake
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL result: unexpected output %h cout=%b ovf=%b, required none", sum, cout, ovf);
      end else begin
        logic [W+1:0] e;
        e = exp_q.pop_front();
        chk("result", {30'd0, ovf, cout, sum}, {30'd0, e});
      end
    end
  end

  // Present an operation and hold it until accepted; expected value pushed at accept
  task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                       input logic xs, input logic [W+1:0] expv);
    logic rdy_pre;
    bit   done;
    done     = 0;
    a        = xa;
    b        = xb;
    cin      = xc;
    sub      = xs;
    in_valid = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      rdy_pre = in_ready;
      @(posedge clk);
      #1;
      if (rdy_pre) begin
        exp_q.push_back(expv);
        done = 1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: in_ready never seen, required accept");
    end
    in_valid = 1'b0;
    a        = $urandom();
    b        = $urandom();
    cin      = 1'($urandom_range(0, 1));
    sub      = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 500 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc, rs;
    int           sel;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Full carry ripple plus latency check: out_valid rises after 4th edge
    issue(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, {1'b0, 1'b1, 32'h00000000});
    chk("accept_in_ready_low", 64'(in_ready), 64'd0);
    for (int i = 1; i <= WORDS; i++) begin
      @(posedge clk); #1;
      chk("latency_out_valid", 64'(out_valid), 64'(i == WORDS));
      chk("latency_busy", 64'(busy), 64'd1);
    end
    wait_drain();

    issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h80000000});
    issue(32'h00000005, 32'h00000007, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFFFFFE});
    issue(32'h80000000, 32'h00000001, 1'b0, 1'b1, {1'b1, 1'b1, 32'h7FFFFFFF});
    issue(32'h00000010, 32'h00000010, 1'b1, 1'b1, {1'b0, 1'b1, 32'h00000000});
    wait_drain();

    // Backpressure: hold out_ready low in DONE while a second request waits
    rdy_mode = 0;
    @(posedge clk); #1;
    issue(32'h00000001, 32'h00000002, 1'b0, 1'b0, {1'b0, 1'b0, 32'h00000003});
    for (int i = 0; i < 20 && !out_valid; i++) begin @(posedge clk); #1; end
    a = 32'hA5A5A5A5; b = 32'h5A5A5A5A; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_sum", 64'(sum), 64'h3);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    rdy_mode = 1;
    issue(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 1'b0, {1'b0, 1'b0, 32'hFFFFFFFF});
    wait_drain();

    // Reset mid-RUN after slice 1 is written: partial result discarded
    issue(32'hDEADBEEF, 32'h01010101, 1'b0, 1'b0, {1'b0, 1'b0, 32'hDFAEBFF0});
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_sum", 64'(sum), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);

    // Reset together with in_valid: no accept
    a = 32'h1; b = 32'h1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_vs_valid_busy", 64'(busy), 64'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("rst_vs_valid_out_valid", 64'(out_valid), 64'd0);

    issue(32'h12345678, 32'h11111111, 1'b0, 1'b0, {1'b0, 1'b0, 32'h23456789});
    wait_drain();

    // Mixed random traffic with random backpressure against the reference model
    rdy_mode = 2;
    for (int n = 0; n < 1000; n++) begin
      sel = $urandom_range(0, 3);
      ra  = $urandom();
      rb  = $urandom();
      if (sel == 0) ra = 32'h7FFFFFFF;
      if (sel == 1) rb = 32'h80000000;
      rc  = 1'($urandom_range(0, 1));
      rs  = 1'($urandom_range(0, 1));
      issue(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end
    rdy_mode = 1;
    wait_drain();
    repeat (8) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
endmodule
